// File: rtl/fu_issue_scheduler_if.sv
// Issue-port, functional-unit and result-bus signals shared between the
// reservation stations and the multi-cycle FU scheduler.
interface fu_issue_scheduler_if #(
    parameter int NUM_REQ   = 4,
    parameter int ROB_IDX_W = 3,
    parameter int LAT_W     = 4
);
    logic [NUM_REQ-1:0]                req_valid;
    logic [NUM_REQ-1:0][ROB_IDX_W-1:0] req_rob_idx;
    logic [NUM_REQ-1:0][LAT_W-1:0]     req_latency;
    logic                              flush;
    logic                              cdb_ready;

    logic [NUM_REQ-1:0]                req_grant;
    logic                              fu_start;
    logic [ROB_IDX_W-1:0]              fu_rob_idx;
    logic                              fu_busy;
    logic                              cdb_valid;
    logic [ROB_IDX_W-1:0]              cdb_rob_idx;

    modport master (
        output req_valid, req_rob_idx, req_latency, flush, cdb_ready,
        input  req_grant, fu_start, fu_rob_idx, fu_busy, cdb_valid, cdb_rob_idx
    );

    modport slave (
        input  req_valid, req_rob_idx, req_latency, flush, cdb_ready,
        output req_grant, fu_start, fu_rob_idx, fu_busy, cdb_valid, cdb_rob_idx
    );
endinterface

// File: rtl/fu_issue_scheduler.sv
// Round-robin issue of ready ops onto one shared multi-cycle FU, with a latency
// down-counter and a backpressured completion broadcast on the result bus.
module fu_issue_scheduler #(
    parameter int NUM_REQ   = 4,
    parameter int ROB_IDX_W = 3,
    parameter int LAT_W     = 4
) (
    input logic                  clk,
    input logic                  rst,
    fu_issue_scheduler_if.slave  bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state, next_state;
    logic [PTR_W-1:0]     rr_ptr, next_rr_ptr;
    logic [LAT_W-1:0]     cnt, next_cnt;
    logic [ROB_IDX_W-1:0] tag, next_tag;

    logic                 arb_en;
    logic                 win_found;
    logic [PTR_W-1:0]     win_idx;
    logic                 grant_any;
    logic [NUM_REQ-1:0]   grant;
    logic [LAT_W-1:0]     win_lat;
    logic [LAT_W-1:0]     load_cnt;
    logic [ROB_IDX_W-1:0] win_rob;

    // Arbitration is closed while reset is held so no grant escapes combinationally.
    assign arb_en = rst && !bus.flush &&
                    ((state == IDLE) || ((state == DONE) && bus.cdb_ready));

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        int               cand;
        logic [PTR_W-1:0] cand_idx;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand     = (int'(rr_ptr) + k) % NUM_REQ;
            cand_idx = PTR_W'(cand);
            if (!win_found && bus.req_valid[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    assign grant_any = arb_en && win_found;
    assign grant     = grant_any ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx) : '0;
    assign win_lat   = bus.req_latency[win_idx];
    assign load_cnt  = (win_lat == '0) ? LAT_W'(1) : win_lat;
    assign win_rob   = bus.req_rob_idx[win_idx];

    always_comb begin
        next_state  = state;
        next_cnt    = cnt;
        next_tag    = tag;
        next_rr_ptr = rr_ptr;
        if (bus.flush) begin
            next_state = IDLE;
            next_cnt   = '0;
        end else begin
            case (state)
                IDLE: next_state = IDLE;
                BUSY: begin
                    next_cnt = cnt - 1'b1;
                    if (cnt <= LAT_W'(1)) begin
                        next_state = DONE;
                    end
                end
                DONE: begin
                    if (bus.cdb_ready) begin
                        next_state = IDLE;
                    end
                end
                default: next_state = IDLE;
            endcase
            // A grant in DONE overlaps the broadcast with the next launch.
            if (grant_any) begin
                next_state = BUSY;
                next_cnt   = load_cnt;
                next_tag   = win_rob;
                if (int'(win_idx) == NUM_REQ - 1) begin
                    next_rr_ptr = '0;
                end else begin
                    next_rr_ptr = win_idx + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            rr_ptr <= '0;
            cnt    <= '0;
            tag    <= '0;
        end else begin
            state  <= next_state;
            rr_ptr <= next_rr_ptr;
            cnt    <= next_cnt;
            tag    <= next_tag;
        end
    end

    assign bus.req_grant   = grant;
    assign bus.fu_start    = grant_any;
    assign bus.fu_rob_idx  = grant_any ? win_rob : tag;
    assign bus.fu_busy     = (state != IDLE);
    assign bus.cdb_valid   = (state == DONE);
    assign bus.cdb_rob_idx = (state == DONE) ? tag : '0;
endmodule

// File: tb/tb_fu_issue_scheduler.sv
// Directed bench for fu_issue_scheduler: reset, latency, round-robin,
// backpressure, flush and asynchronous reset scenarios with hand-computed values.
module tb_fu_issue_scheduler;
    logic clk;
    logic rst;
    int   n_compared;
    int   n_mismatched;
    logic seen_cdb;

    fu_issue_scheduler_if #(.NUM_REQ(4), .ROB_IDX_W(3), .LAT_W(4)) bus ();

    fu_issue_scheduler #(.NUM_REQ(4), .ROB_IDX_W(3), .LAT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] valid, input logic fl, input logic rdy);
        bus.req_valid = valid;
        bus.flush     = fl;
        bus.cdb_ready = rdy;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        seen_cdb     = 1'b0;
        rst          = 1'b0;
        bus.req_rob_idx = '0;
        bus.req_latency = '0;

        // Reset: outputs held at zero even with a valid request present
        bus.req_rob_idx[0] = 3'd5;
        bus.req_latency[0] = 4'd3;
        applyStimulus(4'b0001, 1'b0, 1'b1);
        #12;
        checkOutput("rst_grant", bus.req_grant, 0);
        checkOutput("rst_start", bus.fu_start, 0);
        checkOutput("rst_busy", bus.fu_busy, 0);
        checkOutput("rst_cdb_valid", bus.cdb_valid, 0);
        checkOutput("rst_fu_idx", bus.fu_rob_idx, 0);
        checkOutput("rst_cdb_idx", bus.cdb_rob_idx, 0);

        // Single request, idx 5, L=3
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("t1_grant", bus.req_grant, 4'b0001);
        checkOutput("t1_start", bus.fu_start, 1);
        checkOutput("t1_fu_idx", bus.fu_rob_idx, 5);
        next_cycle();
        applyStimulus(4'b0000, 1'b0, 1'b1);
        #1;
        checkOutput("t1_busy_c1", bus.fu_busy, 1);
        checkOutput("t1_cdb_c1", bus.cdb_valid, 0);
        checkOutput("t1_fu_idx_inflight", bus.fu_rob_idx, 5);
        next_cycle();
        next_cycle();
        checkOutput("t1_cdb_c3", bus.cdb_valid, 0);
        checkOutput("t1_busy_c3", bus.fu_busy, 1);
        next_cycle();
        checkOutput("t1_cdb_c4", bus.cdb_valid, 1);
        checkOutput("t1_cdb_idx_c4", bus.cdb_rob_idx, 5);
        checkOutput("t1_busy_c4", bus.fu_busy, 1);
        next_cycle();
        checkOutput("t1_busy_c5", bus.fu_busy, 0);
        checkOutput("t1_cdb_c5", bus.cdb_valid, 0);

        // L=0 behaves as L=1 (rr_ptr now 1)
        bus.req_rob_idx[1] = 3'd2;
        bus.req_latency[1] = 4'd0;
        applyStimulus(4'b0010, 1'b0, 1'b1);
        #1;
        checkOutput("l0_grant", bus.req_grant, 4'b0010);
        next_cycle();
        applyStimulus(4'b0000, 1'b0, 1'b1);
        #1;
        checkOutput("l0_busy", bus.fu_busy, 1);
        checkOutput("l0_cdb_early", bus.cdb_valid, 0);
        next_cycle();
        checkOutput("l0_cdb", bus.cdb_valid, 1);
        checkOutput("l0_cdb_idx", bus.cdb_rob_idx, 2);
        next_cycle();
        checkOutput("l0_idle", bus.fu_busy, 0);

        // Backpressure (rr_ptr now 2): req3 idx 6 L=2, then req2 waits behind DONE
        bus.req_rob_idx[3] = 3'd6;
        bus.req_latency[3] = 4'd2;
        bus.req_rob_idx[2] = 3'd1;
        bus.req_latency[2] = 4'd1;
        applyStimulus(4'b1000, 1'b0, 1'b0);
        #1;
        checkOutput("bp_grant3", bus.req_grant, 4'b1000);
        next_cycle();
        applyStimulus(4'b0100, 1'b0, 1'b0);
        #1;
        checkOutput("bp_busy_nogrant", bus.req_grant, 0);
        next_cycle();
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            checkOutput("bp_hold_valid", bus.cdb_valid, 1);
            checkOutput("bp_hold_idx", bus.cdb_rob_idx, 6);
            checkOutput("bp_hold_nogrant", bus.req_grant, 0);
            next_cycle();
        end
        applyStimulus(4'b0100, 1'b0, 1'b1);
        #1;
        checkOutput("bp_release_grant", bus.req_grant, 4'b0100);
        checkOutput("bp_release_fu_idx", bus.fu_rob_idx, 1);
        checkOutput("bp_release_cdb", bus.cdb_valid, 1);
        next_cycle();
        applyStimulus(4'b0000, 1'b0, 1'b1);
        #1;
        checkOutput("bp_b2b_cdb", bus.cdb_valid, 0);
        checkOutput("bp_b2b_busy", bus.fu_busy, 1);
        next_cycle();
        checkOutput("bp_b2b_done", bus.cdb_valid, 1);
        checkOutput("bp_b2b_idx", bus.cdb_rob_idx, 1);
        next_cycle();

        // Flush during BUSY (rr_ptr now 3): req0 idx 4 L=8, flush in cycle 3
        bus.req_rob_idx[0] = 3'd4;
        bus.req_latency[0] = 4'd8;
        applyStimulus(4'b0001, 1'b0, 1'b1);
        #1;
        checkOutput("fl_grant_wrap", bus.req_grant, 4'b0001);
        next_cycle();
        applyStimulus(4'b0000, 1'b0, 1'b1);
        next_cycle();
        next_cycle();
        applyStimulus(4'b0000, 1'b1, 1'b1);
        #1;
        checkOutput("fl_busy_before", bus.fu_busy, 1);
        next_cycle();
        applyStimulus(4'b0000, 1'b0, 1'b1);
        #1;
        checkOutput("fl_idle", bus.fu_busy, 0);
        checkOutput("fl_cdb", bus.cdb_valid, 0);
        for (int i = 0; i < 10; i++) begin
            seen_cdb = seen_cdb | bus.cdb_valid;
            next_cycle();
        end
        checkOutput("fl_no_cdb_ever", seen_cdb, 0);

        // Flush beats a coincident grant; rr_ptr preserved at 1
        bus.req_rob_idx[2] = 3'd3;
        bus.req_latency[2] = 4'd8;
        applyStimulus(4'b0101, 1'b1, 1'b1);
        #1;
        checkOutput("fl_beats_grant", bus.req_grant, 0);
        applyStimulus(4'b0101, 1'b0, 1'b1);
        #1;
        checkOutput("fl_rr_kept", bus.req_grant, 4'b0100);
        next_cycle();
        applyStimulus(4'b0000, 1'b0, 1'b1);
        next_cycle();

        // Async reset mid-BUSY between edges
        #1;
        rst = 1'b0;
        #1;
        checkOutput("ar_busy", bus.fu_busy, 0);
        checkOutput("ar_cdb", bus.cdb_valid, 0);
        checkOutput("ar_grant", bus.req_grant, 0);
        checkOutput("ar_fu_idx", bus.fu_rob_idx, 0);

        // Round-robin after reset: all valid, L=1
        for (int i = 0; i < 4; i++) begin
            bus.req_rob_idx[i] = 3'(7 - i);
            bus.req_latency[i] = 4'd1;
        end
        applyStimulus(4'b1111, 1'b0, 1'b1);
        #1;
        checkOutput("ar_grant_held", bus.req_grant, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        for (int g = 0; g < 5; g++) begin
            checkOutput("rr_grant", bus.req_grant, 1 << (g % 4));
            checkOutput("rr_fu_idx", bus.fu_rob_idx, 7 - (g % 4));
            next_cycle();
            checkOutput("rr_gap", bus.req_grant, 0);
            next_cycle();
            checkOutput("rr_cdb_valid", bus.cdb_valid, 1);
            checkOutput("rr_cdb_idx", bus.cdb_rob_idx, 7 - (g % 4));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
